// File: rtl/ble_link_rx.sv
// BLE link-layer bit-stream receiver: access-address hunt with error tolerance,
// dewhitening, header-driven PDU byte streaming and CRC-24 check.
module ble_link_rx #(
  parameter int                   AA_LEN      = 32,
  parameter int                   AA_MAX_ERR  = 1,
  parameter int                   MAX_PAYLOAD = 255,
  parameter int                   CRC_LEN     = 24,
  parameter logic [CRC_LEN-1:0]   CRC_POLY    = 24'h00065B
) (
  input  logic               symbol_clk,
  input  logic               rst,
  input  logic               en,
  input  logic               symbol_valid,
  input  logic               symbol_in,
  input  logic [AA_LEN-1:0]  acc_addr,
  input  logic [5:0]         channel,
  input  logic [CRC_LEN-1:0] crc_init,
  output logic [7:0]         byte_out,
  output logic               byte_valid,
  output logic               byte_last,
  output logic               pkt_done,
  output logic               crc_ok,
  output logic               len_err,
  output logic [8:0]         pdu_len,
  output logic               busy
);

  localparam int         AW      = $clog2(AA_LEN + 1);
  localparam int         CW      = $clog2(CRC_LEN);
  localparam logic [8:0] LEN_MAX = 9'(MAX_PAYLOAD);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CRC     = 2'd3
  } state_t;

  state_t             state_r;
  logic [AA_LEN-1:0]  aa_sr_r;
  logic [AA_LEN-1:0]  aa_next_s;
  logic [AW-1:0]      aa_cnt_r;
  logic [6:0]         whit_r;
  logic [6:0]         whit_next_s;
  logic [CRC_LEN-1:0] crc_r;
  logic [CRC_LEN-1:0] crc_next_s;
  logic [7:0]         byte_sh_r;
  logic [7:0]         byte_next_s;
  logic [2:0]         bit_cnt_r;
  logic [8:0]         byte_cnt_r;
  logic [CW-1:0]      crc_cnt_r;
  logic               d_s;
  logic               aa_hit_s;

  function automatic int aa_distance(input logic [AA_LEN-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < AA_LEN; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [CRC_LEN-1:0] crc_step(input logic [CRC_LEN-1:0] c, input logic d);
    logic fb;
    fb = c[CRC_LEN-1] ^ d;
    return {c[CRC_LEN-2:0], 1'b0} ^ (fb ? CRC_POLY : {CRC_LEN{1'b0}});
  endfunction

  // Next-bit datapath: AA window, dewhitened bit, LFSR/CRC advance, byte assembly
  always_comb begin
    aa_next_s   = {symbol_in, aa_sr_r[AA_LEN-1:1]};
    d_s         = symbol_in ^ whit_r[0];
    whit_next_s = {whit_r[0], whit_r[6:4], whit_r[3] ^ whit_r[0], whit_r[2:1]};
    crc_next_s  = crc_step(crc_r, d_s);
    byte_next_s = byte_sh_r;
    byte_next_s[bit_cnt_r] = d_s;
    if (aa_cnt_r >= AW'(AA_LEN - 1)) begin
      aa_hit_s = (aa_distance(aa_next_s ^ acc_addr) <= AA_MAX_ERR);
    end else begin
      aa_hit_s = 1'b0;
    end
  end

  // Receiver FSM with registered outputs; pulses default low every edge
  always_ff @(posedge symbol_clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_HUNT;
      aa_sr_r    <= '0;
      aa_cnt_r   <= '0;
      whit_r     <= {1'b1, channel};
      crc_r      <= crc_init;
      byte_sh_r  <= 8'd0;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= 9'd0;
      crc_cnt_r  <= '0;
      byte_out   <= 8'd0;
      byte_valid <= 1'b0;
      byte_last  <= 1'b0;
      pkt_done   <= 1'b0;
      crc_ok     <= 1'b0;
      len_err    <= 1'b0;
      pdu_len    <= 9'd0;
      busy       <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_last  <= 1'b0;
      pkt_done   <= 1'b0;
      if (!en) begin
        state_r    <= ST_HUNT;
        busy       <= 1'b0;
        aa_sr_r    <= '0;
        aa_cnt_r   <= '0;
        whit_r     <= {1'b1, channel};
        crc_r      <= crc_init;
        bit_cnt_r  <= 3'd0;
        byte_cnt_r <= 9'd0;
        crc_cnt_r  <= '0;
      end else if (symbol_valid) begin
        case (state_r)
          ST_HUNT: begin
            aa_sr_r <= aa_next_s;
            if (aa_cnt_r != AW'(AA_LEN)) begin
              aa_cnt_r <= aa_cnt_r + AW'(1);
            end
            if (aa_hit_s) begin
              state_r    <= ST_HEADER;
              busy       <= 1'b1;
              whit_r     <= {1'b1, channel};
              crc_r      <= crc_init;
              bit_cnt_r  <= 3'd0;
              byte_cnt_r <= 9'd0;
              crc_cnt_r  <= '0;
              crc_ok     <= 1'b0;
              len_err    <= 1'b0;
              pdu_len    <= 9'd0;
            end
          end
          ST_HEADER, ST_PAYLOAD: begin
            whit_r    <= whit_next_s;
            crc_r     <= crc_next_s;
            byte_sh_r <= byte_next_s;
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              byte_out   <= byte_next_s;
              byte_valid <= 1'b1;
              byte_cnt_r <= byte_cnt_r + 9'd1;
              if (state_r == ST_HEADER && byte_cnt_r == 9'd1) begin
                pdu_len    <= {1'b0, byte_next_s};
                byte_cnt_r <= 9'd0;
                if ({1'b0, byte_next_s} > LEN_MAX) begin
                  // oversize length: report and resume hunting immediately
                  pkt_done <= 1'b1;
                  len_err  <= 1'b1;
                  crc_ok   <= 1'b0;
                  state_r  <= ST_HUNT;
                  busy     <= 1'b0;
                  aa_sr_r  <= '0;
                  aa_cnt_r <= '0;
                end else if (byte_next_s == 8'd0) begin
                  byte_last <= 1'b1;
                  state_r   <= ST_CRC;
                end else begin
                  state_r <= ST_PAYLOAD;
                end
              end else if (state_r == ST_PAYLOAD && (byte_cnt_r + 9'd1) == pdu_len) begin
                byte_last <= 1'b1;
                state_r   <= ST_CRC;
              end
            end
          end
          ST_CRC: begin
            whit_r    <= whit_next_s;
            crc_r     <= crc_next_s;
            crc_cnt_r <= crc_cnt_r + CW'(1);
            if (crc_cnt_r == CW'(CRC_LEN - 1)) begin
              pkt_done <= 1'b1;
              crc_ok   <= (crc_next_s == {CRC_LEN{1'b0}});
              len_err  <= 1'b0;
              state_r  <= ST_HUNT;
              busy     <= 1'b0;
              aa_sr_r  <= '0;
              aa_cnt_r <= '0;
            end
          end
          default: begin
            state_r <= ST_HUNT;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ble_link_rx.sv
// Scoreboard bench for ble_link_rx: a bit-level packet model builds the on-air
// stream and the expected byte/packet events; a negedge monitor records outputs.
module tb_ble_link_rx;
  localparam logic [31:0] AA    = 32'h8E89BED6;
  localparam logic [5:0]  CHAN  = 6'd37;
  localparam logic [23:0] CINIT = 24'h555555;
  localparam logic [23:0] POLY  = 24'h00065B;
  localparam int          MAXP  = 37;

  logic        symbol_clk, rst, en, symbol_valid, symbol_in;
  logic [31:0] acc_addr;
  logic [5:0]  channel;
  logic [23:0] crc_init;
  logic [7:0]  byte_out;
  logic        byte_valid, byte_last, pkt_done, crc_ok, len_err, busy;
  logic [8:0]  pdu_len;

  int checks = 0;
  int failures = 0;
  logic [7:0]  pdu_q[$];
  bit          tx_q[$];
  logic [19:0] exp_q[$];
  logic [19:0] obs_q[$];
  bit          busy_seen;

  ble_link_rx #(.AA_LEN(32), .AA_MAX_ERR(1), .MAX_PAYLOAD(MAXP), .CRC_LEN(24), .CRC_POLY(POLY)) dut (
    .symbol_clk(symbol_clk), .rst(rst), .en(en), .symbol_valid(symbol_valid), .symbol_in(symbol_in),
    .acc_addr(acc_addr), .channel(channel), .crc_init(crc_init), .byte_out(byte_out),
    .byte_valid(byte_valid), .byte_last(byte_last), .pkt_done(pkt_done), .crc_ok(crc_ok),
    .len_err(len_err), .pdu_len(pdu_len), .busy(busy)
  );

  initial begin
    symbol_clk = 1'b0;
    forever #5 symbol_clk = ~symbol_clk;
  end

  // Event words: byte = {1, last, data}; packet = {2, busy, crc_ok, len_err, pdu_len}
  always @(negedge symbol_clk) begin
    if (byte_valid) obs_q.push_back({4'h1, 7'd0, byte_last, byte_out});
    if (pkt_done) obs_q.push_back({4'h2, 4'd0, busy, crc_ok, len_err, pdu_len});
    if (busy) busy_seen = 1'b1;
  end

  // Appends preamble+AA+whitened PDU+CRC to tx_q and the expected events to exp_q
  task automatic build_pkt(input logic [31:0] aa, input int flip);
    logic [23:0] c;
    logic [6:0]  w;
    logic [7:0]  b;
    logic        d;
    int          plen, nbytes;
    bit          abort;
    c = CINIT;
    w = {1'b1, CHAN};
    plen = int'(pdu_q[1]);
    abort = (plen > MAXP);
    nbytes = abort ? 2 : plen + 2;
    for (int i = 0; i < 8; i++) tx_q.push_back(aa[0] ^ bit'(i % 2));
    for (int i = 0; i < 32; i++) tx_q.push_back(aa[i]);
    for (int k = 0; k < nbytes; k++) begin
      b = pdu_q[k];
      for (int j = 0; j < 8; j++) begin
        d = b[j];
        c = {c[22:0], 1'b0} ^ ((c[23] ^ d) ? POLY : 24'h000000);
        if (k * 8 + j == flip) begin
          d = ~d;
          b[j] = d;
        end
        tx_q.push_back(d ^ w[0]);
        w = {w[0], w[6:4], w[3] ^ w[0], w[2:1]};
      end
      exp_q.push_back({4'h1, 7'd0, (!abort && k == nbytes - 1), b});
    end
    if (!abort) begin
      for (int j = 23; j >= 0; j--) begin
        tx_q.push_back(c[j] ^ w[0]);
        w = {w[0], w[6:4], w[3] ^ w[0], w[2:1]};
      end
    end
    exp_q.push_back({4'h2, 4'd0, 1'b0, (!abort && flip < 0), abort, 9'(plen)});
  endtask

  task automatic send(input int gap);
    foreach (tx_q[i]) begin
      symbol_in = tx_q[i];
      symbol_valid = 1'b1;
      @(posedge symbol_clk); #1;
      for (int g = 0; g < gap; g++) begin
        symbol_valid = 1'b0;
        symbol_in = 1'($urandom);
        @(posedge symbol_clk); #1;
      end
    end
    symbol_valid = 1'b0;
    repeat (4) begin @(posedge symbol_clk); #1; end
    tx_q.delete();
  endtask

  task automatic start_test();
    tx_q.delete(); exp_q.delete(); obs_q.delete(); pdu_q.delete();
    busy_seen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; symbol_valid = 1'b0; symbol_in = 1'b0;
    acc_addr = AA; channel = CHAN; crc_init = CINIT;
    #12;
    checks++;
    if ({byte_out, byte_valid, byte_last, pkt_done, crc_ok, len_err, pdu_len, busy} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h expected=0", {byte_out, byte_valid, byte_last, pkt_done, crc_ok, len_err, pdu_len, busy});
    end
    #10 rst = 1'b1;
    @(posedge symbol_clk); #1;
    checks++;
    if ({busy, pkt_done, byte_valid} !== 3'd0) begin
      failures++;
      $display("FAIL reset_release got=%b expected=000", {busy, pkt_done, byte_valid});
    end
  endtask

  task automatic test_adv_ind();
    logic [19:0] e, o;
    start_test();
    pdu_q = '{8'h40, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    build_pkt(AA, -1);
    send(0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL adv_count got=%0d expected=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL adv_event got=%h expected=%h", o, e); end
    end
    checks++;
    if (pdu_len !== 9'd6 || crc_ok !== 1'b1) begin
      failures++; $display("FAIL adv_hold got=%0d/%b expected=6/1", pdu_len, crc_ok);
    end
  endtask

  task automatic test_aa_tolerance();
    logic [19:0] e, o;
    start_test();
    pdu_q = '{8'h40, 8'h06, 8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4, 8'hF5};
    build_pkt(AA ^ 32'h0000_0100, -1);
    send(0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL aa1_count got=%0d expected=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL aa1_event got=%h expected=%h", o, e); end
    end
    start_test();
    pdu_q = '{8'h40, 8'h06, 8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4, 8'hF5};
    build_pkt(AA ^ 32'h0001_0010, -1);
    exp_q.delete();
    send(0);
    checks++;
    if (obs_q.size() != 0 || busy_seen !== 1'b0) begin
      failures++; $display("FAIL aa2_reject got=%0d events busy=%b expected=0 events busy=0", obs_q.size(), busy_seen);
    end
  endtask

  task automatic test_payload_error();
    logic [19:0] e, o;
    start_test();
    pdu_q = '{8'h40, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    build_pkt(AA, 26);
    send(0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL crcerr_count got=%0d expected=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL crcerr_event got=%h expected=%h", o, e); end
    end
  endtask

  task automatic test_len_abort();
    logic [19:0] e, o;
    start_test();
    pdu_q = '{8'h40, 8'hFF};
    build_pkt(AA, -1);
    send(0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL lenerr_count got=%0d expected=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL lenerr_event got=%h expected=%h", o, e); end
    end
    checks++;
    if ({busy, len_err, crc_ok} !== 3'b010) begin
      failures++; $display("FAIL lenerr_hold got=%b expected=010", {busy, len_err, crc_ok});
    end
  endtask

  task automatic test_en_drop();
    logic [19:0] e, o;
    start_test();
    pdu_q = '{8'h40, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    build_pkt(AA, -1);
    while (tx_q.size() > 80) void'(tx_q.pop_back());
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    send(0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL endrop_busy_before got=%b expected=1", busy); end
    en = 1'b0;
    @(posedge symbol_clk); #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL endrop_busy_after got=%b expected=0", busy); end
    en = 1'b1;
    pdu_q = '{8'h40, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    build_pkt(AA, -1);
    send(0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL endrop_count got=%0d expected=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL endrop_event got=%h expected=%h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] e, o;
    for (int gap = 0; gap <= 3; gap += 3) begin
      start_test();
      pdu_q = '{8'h43, 8'h00};
      build_pkt(AA, -1);
      pdu_q = '{8'h40, 8'h03, 8'hA1, 8'hB2, 8'hC3};
      build_pkt(AA, -1);
      send(gap);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        failures++; $display("FAIL b2b_count gap=%0d got=%0d expected=%0d", gap, obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
        if (o !== e) begin failures++; $display("FAIL b2b_event gap=%0d got=%h expected=%h", gap, o, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_adv_ind();
    test_aa_tolerance();
    test_payload_error();
    test_len_abort();
    test_en_drop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ble_link_rx.md
Name: ble_link_rx

Overview:
Parametrised BLE link-layer bit-stream receiver: hunts a configurable access address with bit-error tolerance, then dewhitens, parses the 2-byte PDU header, streams PDU bytes out, and checks CRC-24. Sits after the GFSK demodulator/symbol slicer and feeds the packet FIFO/host interface. Single clock edge, explicit symbol strobe, header-driven length.

Parameters:
AA_LEN, 32, access-address length in bits
AA_MAX_ERR, 1, max Hamming distance accepted on access-address match (0..3)
MAX_PAYLOAD, 255, max payload bytes; a larger header length aborts the packet
CRC_LEN, 24, CRC register width
CRC_POLY, 24'h00065B, CRC feedback polynomial (x^24 term implicit)

Ports:
symbol_clk  in  1  clock; all logic on posedge
rst  in  1  reset, asynchronous, active-low
en  in  1  receiver enable; low forces HUNT and aborts any packet
symbol_valid  in  1  qualifies symbol_in; all state advances only when high
symbol_in  in  1  demodulated bit, on-air order (LSB-first per byte)
acc_addr  in  AA_LEN  target access address; acc_addr[0] is first on air
channel  in  6  BLE channel index, whitening seed
crc_init  in  CRC_LEN  CRC preset (24'h555555 for advertising)
byte_out  out  8  dewhitened PDU byte, first received bit in bit 0
byte_valid  out  1  one-cycle pulse, byte_out valid
byte_last  out  1  with byte_valid, marks final PDU byte
pkt_done  out  1  one-cycle pulse at end of packet (normal or length abort)
crc_ok  out  1  valid with pkt_done; 1 = CRC passed
len_err  out  1  valid with pkt_done; 1 = header length > MAX_PAYLOAD
pdu_len  out  9  payload length from header, held from header byte 2 until next AA match
busy  out  1  high in any state except HUNT

Behaviour:
- Reset: all outputs 0; FSM = HUNT; AA shift register, bit/byte counters 0; whitening LFSR = {1'b1, channel}; CRC register = crc_init.
- "Step" = posedge with symbol_valid=1 and en=1. No step: nothing changes, pulses deassert.
- en=0 on any posedge: FSM -> HUNT, AA register cleared, LFSR/CRC reloaded, no pkt_done; outputs other than pulses hold.
- HUNT: AA register shifts in at MSB (sr <= {symbol_in, sr[AA_LEN-1:1]}). On a step, if popcount(next sr ^ acc_addr) <= AA_MAX_ERR -> HEADER; reload LFSR = {1'b1, channel}, CRC = crc_init, counters 0. Match tested only once >= AA_LEN bits have been shifted since entering HUNT (valid-bit counter saturating at AA_LEN).
- Dewhitening per step outside HUNT: d = symbol_in ^ w[0]; w <= {w[0], w[6:1]} with new w[2] additionally XOR w[0].
- CRC per step in HEADER/PAYLOAD/CRC: fb = c[23] ^ d; c <= {c[22:0],0} ^ (fb ? CRC_POLY : 0). Received CRC bits are fed identically; pass iff c == 0 after the last CRC bit.
- Byte assembly: d shifted into bit (count mod 8); byte_valid pulses on the posedge that captures bit 7 of each header/payload byte. CRC bytes are never emitted.
- HEADER: 16 bits. At byte 2 completion pdu_len <= {1'b0, byte2}. If pdu_len > MAX_PAYLOAD: pkt_done=1, len_err=1, crc_ok=0, byte_last=0 -> HUNT. Else len 0 -> CRC with byte_last=1 on byte 2; else -> PAYLOAD.
- PAYLOAD: pdu_len bytes; byte_last=1 on last -> CRC.
- CRC: CRC_LEN bits; on last bit pkt_done=1, crc_ok=(c_next==0), len_err=0 -> HUNT with AA register cleared (next packet needs AA_LEN fresh bits).
- Latency: byte_valid same edge as its 8th bit; pkt_done same edge as last CRC bit.
- crc_ok/len_err hold until next pkt_done or next AA match (cleared on match).

Test Plan:
- AA 32'h8E89BED6, channel 37, crc_init 24'h555555, ADV_IND header 0x40,0x06 + 6-byte payload with golden-model whitening/CRC -> 8 byte_valid pulses, byte_last on 8th, pkt_done with crc_ok=1, pdu_len=6.
- Same packet, AA with 1 bit flipped (AA_MAX_ERR=1) -> accepted, crc_ok=1; 2 bits flipped -> no busy, no pkt_done.
- Flip one payload bit -> bytes still streamed, pkt_done with crc_ok=0.
- Header length 0xFF with MAX_PAYLOAD=37 -> pkt_done after byte 2 with len_err=1, crc_ok=0, busy low next cycle.
- Drop en at payload byte 3 -> busy 0 next edge, no pkt_done; a following clean packet decodes with crc_ok=1.
- Length-0 PDU, then back-to-back packet after 8 preamble bits; symbol_valid toggling 1-in-4 -> both pkt_done with crc_ok=1, identical output to continuous-valid run.
